// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshake and per-packet channel lock.
// Optional DEMUX_DROP_CNT_EN adds a saturating 16-bit counter of dropped packets (drop_cnt).
//
// state  | meaning
// S_IDLE | waiting for the first beat of a packet
// S_PKT  | forwarding beats to the locked channel
// S_DROP | discarding a packet whose select was out of range
module stream_demux_1xn #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [SELW-1:0]  in_sel,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef DEMUX_DROP_CNT_EN
  , output logic [15:0]    drop_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SELW-1:0]  r_ch;
  logic             r_vld;
  logic [WIDTH-1:0] r_data;
  logic             r_last;

  logic w_held_ready;
  logic w_sel_ok;
  logic w_accept;
  logic w_retire;
  logic w_fwd;

  // Ready of the channel owning the held beat; other channels' ready is ignored.
  always_comb begin
    w_held_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (r_ch == SELW'(k)) w_held_ready = out_ready[k];
    end
  end

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < N; k++) begin
      out_valid[k] = r_vld && (r_ch == SELW'(k));
    end
  end

  // Extra bit keeps the compare correct when N == 2**SELW.
  assign w_sel_ok = ({1'b0, in_sel} < (SELW+1)'(N));
  assign in_ready = (r_state == S_DROP) || !r_vld || w_held_ready;
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_vld && w_held_ready;
  assign out_data = r_data;
  assign out_last = r_last;
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_sel_ok) begin
            w_fwd = 1'b1;
            if (!in_last) w_state_nxt = S_PKT;
          end else if (!in_last) begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_PKT: begin
        if (w_accept) begin
          w_fwd = 1'b1;
          if (in_last) w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_accept && in_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_ch   <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_fwd) begin
      r_vld  <= 1'b1;
      r_data <= in_data;
      r_last <= in_last;
      if (r_state == S_IDLE) r_ch <= in_sel;
    end else if (w_retire) begin
      r_vld <= 1'b0;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic w_drop_start;
  assign w_drop_start = (r_state == S_IDLE) && w_accept && !w_sel_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (w_drop_start && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Directed self-checking bench for stream_demux_1xn (N=4, WIDTH=8, SELW=4).
// Drop counter checks are included when DEMUX_DROP_CNT_EN is defined.
module tb_stream_demux_1xn;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [3:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux_1xn #(.WIDTH(8), .N(4), .SELW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] s, input logic l);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 4'b0000;
    drive(1'b0, 8'h00, 4'h0, 1'b0);

    // Reset then idle
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
`ifdef DEMUX_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    step();

    // Single-beat routing to ch2
    out_ready = 4'b1111;
    drive(1'b1, 8'hA5, 4'd2, 1'b1);
    #1 check("single_in_ready", 32'(in_ready), 32'h1);
    step();
    check("single_out_valid", 32'(out_valid), 32'h4);
    check("single_out_data", 32'(out_data), 32'hA5);
    check("single_out_last", 32'(out_last), 32'h1);
    check("single_busy", 32'(busy), 32'h0);
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    step();
    check("single_retired", 32'(out_valid), 32'h0);

    // Packet lock: sel only honoured on the first beat
    drive(1'b1, 8'h11, 4'd1, 1'b0);
    step();
    check("lock_b0_valid", 32'(out_valid), 32'h2);
    check("lock_b0_data", 32'(out_data), 32'h11);
    check("lock_b0_busy", 32'(busy), 32'h1);
    drive(1'b1, 8'h22, 4'd3, 1'b0);
    step();
    check("lock_b1_valid", 32'(out_valid), 32'h2);
    check("lock_b1_data", 32'(out_data), 32'h22);
    check("lock_b1_busy", 32'(busy), 32'h1);
    drive(1'b1, 8'h33, 4'd3, 1'b1);
    step();
    check("lock_b2_valid", 32'(out_valid), 32'h2);
    check("lock_b2_data", 32'(out_data), 32'h33);
    check("lock_b2_last", 32'(out_last), 32'h1);
    check("lock_b2_busy", 32'(busy), 32'h0);
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    step();
    check("lock_retired", 32'(out_valid), 32'h0);

    // Backpressure on ch0; readiness of other channels must not release it
    out_ready = 4'b0000;
    drive(1'b1, 8'h5A, 4'd0, 1'b1);
    step();
    check("bp_held_valid", 32'(out_valid), 32'h1);
    check("bp_held_data", 32'(out_data), 32'h5A);
    drive(1'b1, 8'h77, 4'd0, 1'b1);
    out_ready = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_stable_data", 32'(out_data), 32'h5A);
      check("bp_stable_valid", 32'(out_valid), 32'h1);
      step();
    end
    out_ready = 4'b0001;
    #1 check("bp_release_in_ready", 32'(in_ready), 32'h1);
    step();
    check("bp_next_valid", 32'(out_valid), 32'h1);
    check("bp_next_data", 32'(out_data), 32'h77);
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    step();
    check("bp_retired", 32'(out_valid), 32'h0);

    // Drop: out-of-range select on a 2-beat packet
    out_ready = 4'b1111;
    drive(1'b1, 8'h99, 4'd5, 1'b0);
    #1 check("drop_b0_in_ready", 32'(in_ready), 32'h1);
    step();
    check("drop_b0_valid", 32'(out_valid), 32'h0);
    check("drop_b0_busy", 32'(busy), 32'h1);
`ifdef DEMUX_DROP_CNT_EN
    check("drop_cnt_1", 32'(drop_cnt), 32'h1);
`endif
    drive(1'b1, 8'h9A, 4'd0, 1'b1);
    #1 check("drop_b1_in_ready", 32'(in_ready), 32'h1);
    step();
    check("drop_b1_valid", 32'(out_valid), 32'h0);
    check("drop_b1_busy", 32'(busy), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    check("drop_cnt_still_1", 32'(drop_cnt), 32'h1);
`endif

    // Reset mid-packet on ch3
    drive(1'b1, 8'hD0, 4'd3, 1'b0);
    step();
    check("mid_b0_valid", 32'(out_valid), 32'h8);
    check("mid_b0_busy", 32'(busy), 32'h1);
    drive(1'b1, 8'hD1, 4'd3, 1'b0);
    step();
    check("mid_b1_data", 32'(out_data), 32'hD1);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    step();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    check("mid_rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    drive(1'b1, 8'hE0, 4'd0, 1'b1);
    step();
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_data", 32'(out_data), 32'hE0);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Single-beat drop with max select stays in IDLE
    drive(1'b1, 8'hF0, 4'd15, 1'b1);
    step();
    check("sdrop_valid", 32'(out_valid), 32'h0);
    check("sdrop_busy", 32'(busy), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    check("sdrop_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
